// File: rtl/imem_loader.sv
// imem_loader: packs a boot byte stream big-endian into RAM words and holds the CPU in reset until the image is in
module imem_loader #(
    parameter int MEM_DEPTH  = 1024,
    parameter int RESET_HOLD = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_byte,
    input  logic                         in_last,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic                         busy,
    output logic                         cpu_reset,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(MEM_DEPTH):0]   words_loaded
);
    localparam int WW = $clog2(MEM_DEPTH) + 1;
    localparam int HW = $clog2(RESET_HOLD + 1);
    typedef enum logic [2:0] {LOAD, PAD, HOLD, RUN, ERR} state_t;
    state_t         state;
    logic [1:0]     byte_cnt;
    logic [31:0]    acc;
    logic [31:0]    pack_w;
    logic [31:0]    addr_w;
    logic [HW-1:0]  hold_cnt;
    // lane 0 restarts the word so unfilled low lanes of a padded word read as zero
    always_comb begin
        pack_w = (byte_cnt == 2'd0 ? 32'd0 : acc) | ({24'd0, in_byte} << {~byte_cnt, 3'b000});
        addr_w = 32'(words_loaded) << 2;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            in_ready     <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            busy         <= 1'b1;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            acc          <= 32'd0;
            hold_cnt     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                LOAD: if (in_valid && in_ready) begin
                    if (words_loaded == WW'(MEM_DEPTH)) begin
                        state    <= ERR;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        acc      <= pack_w;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= addr_w;
                            mem_wdata    <= pack_w;
                            words_loaded <= words_loaded + 1'b1;
                        end
                        if (in_last) begin
                            state    <= (byte_cnt == 2'd3) ? HOLD : PAD;
                            in_ready <= 1'b0;
                            hold_cnt <= HW'(RESET_HOLD);
                        end
                    end
                end
                PAD: begin
                    mem_we       <= 1'b1;
                    mem_addr     <= addr_w;
                    mem_wdata    <= acc;
                    words_loaded <= words_loaded + 1'b1;
                    byte_cnt     <= 2'd0;
                    hold_cnt     <= HW'(RESET_HOLD);
                    state        <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= RUN;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader with a 4-word RAM so overflow and full-depth images are reachable
module tb_imem_loader;
    localparam int DEPTH = 4;
    localparam int HOLD_N = 4;
    logic        clk = 0, reset = 1, in_valid = 0, in_last = 0;
    logic [7:0]  in_byte = 0;
    logic        in_ready, mem_we, busy, cpu_reset, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic [$clog2(DEPTH):0] words_loaded;
    logic [63:0] q[$];
    int n_cmp = 0, n_bad = 0, cyc = 0, last_we_cyc = 0;
    logic prev_we = 0;

    imem_loader #(.MEM_DEPTH(DEPTH), .RESET_HOLD(HOLD_N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            logic [63:0] e;
            chk("we_pulse", 32'(prev_we), 0);
            chk("unexp_we", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_addr", mem_addr, e[63:32]);
                chk("wr_data", mem_wdata, e[31:0]);
            end
            last_we_cyc = cyc;
        end
        prev_we = mem_we;
    end

    task automatic do_reset();
        in_valid = 0; in_last = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1; in_byte = b; in_last = last;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
        else begin @(posedge clk); #1; end
        in_valid = 0; in_last = 0;
    endtask

    task automatic run_image(input logic [7:0] bs[$], input logic use_last, input int maxgap);
        for (int i = 0; i < bs.size(); i++)
            send(bs[i], use_last && i == bs.size() - 1, int'($urandom_range(0, maxgap)));
    endtask

    task automatic expect_img(input logic [7:0] bs[$]);
        logic [31:0] w;
        for (int k = 0; k < (bs.size() + 3) / 4 && k < DEPTH; k++) begin
            w = 0;
            for (int j = 0; j < 4; j++)
                if (4 * k + j < bs.size()) w[31 - 8 * j -: 8] = bs[4 * k + j];
            q.push_back({32'(4 * k), w});
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("done", 32'(done), 1);
        chk("sb_empty", q.size(), 0);
    endtask

    initial begin
        logic [7:0] bs[$];
        int n, bad;
        do_reset();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_cpu_reset", 32'(cpu_reset), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_words", 32'(words_loaded), 0);

        bs = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        q.push_back({32'd0, 32'h20080005});
        q.push_back({32'd4, 32'h20090007});
        run_image(bs, 1, 0);
        n = 0;
        while (cpu_reset && n < 100) begin @(negedge clk); n++; end
        chk("release_lat", cyc - last_we_cyc, HOLD_N + 1);
        chk("full_done", 32'(done), 1);
        chk("full_busy", 32'(busy), 0);
        chk("full_words", 32'(words_loaded), 2);
        chk("sb_empty", q.size(), 0);

        do_reset();
        bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        q.push_back({32'd0, 32'hAABBCCDD});
        q.push_back({32'd4, 32'hEE000000});
        run_image(bs, 1, 0);
        wait_done();
        chk("part_words", 32'(words_loaded), 2);

        do_reset();
        bs = '{8'h5A};
        q.push_back({32'd0, 32'h5A000000});
        run_image(bs, 1, 0);
        wait_done();
        chk("one_words", 32'(words_loaded), 1);

        do_reset();
        bs = {};
        for (int i = 0; i < 12; i++) bs.push_back(8'($urandom));
        expect_img(bs);
        run_image(bs, 1, 3);
        wait_done();
        chk("bp_words", 32'(words_loaded), 3);

        do_reset();
        bs = {};
        for (int i = 0; i < 16; i++) bs.push_back(8'(8'h30 + i));
        expect_img(bs);
        run_image(bs, 1, 1);
        wait_done();
        chk("full_depth_err", 32'(error), 0);
        chk("full_depth_words", 32'(words_loaded), DEPTH);

        do_reset();
        bs = {};
        for (int i = 0; i < 17; i++) bs.push_back(8'(i + 1));
        expect_img(bs);
        run_image(bs, 0, 0);
        repeat (3) @(negedge clk);
        chk("ovf_error", 32'(error), 1);
        chk("ovf_cpu_reset", 32'(cpu_reset), 1);
        chk("ovf_busy", 32'(busy), 1);
        chk("ovf_done", 32'(done), 0);
        chk("ovf_in_ready", 32'(in_ready), 0);
        chk("ovf_words", 32'(words_loaded), DEPTH);
        chk("sb_empty", q.size(), 0);

        do_reset();
        bs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        q.push_back({32'd0, 32'h11223344});
        run_image(bs, 0, 0);
        do_reset();
        @(negedge clk);
        chk("mid_rst_words", 32'(words_loaded), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        bs = '{8'h01, 8'h02, 8'h03, 8'h04};
        q.push_back({32'd0, 32'h01020304});
        run_image(bs, 1, 0);
        wait_done();
        chk("mid_words", 32'(words_loaded), 1);

        in_valid = 1; in_last = 1; in_byte = 8'hFF; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (in_ready || !done || busy || cpu_reset) bad++;
        end
        in_valid = 0; in_last = 0;
        chk("run_stable", bad, 0);
        chk("run_words", 32'(words_loaded), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
